blink_timer: RTL
================

// Module: blink_timer
// PURPOSE
//  Segment timer that paces the blink state machine. When the state machine raises its
//  count request, the timer latches the requested length in ticks and counts prescaled ticks.
//  At the end of the segment it returns a one-cycle enable pulse, which advances the state machine.
//  It sits directly downstream of the blink state machine and feeds its i_enable input.
//  One tick is 1 s at 50 MHz by default.
// PARAMETERS
//  CYCLES_PER_TICK  50_000_000  clock cycles per tick; must be >=2 (bench uses 4)
//  CNT_W            3           width of tick-count request/target
// PORTS
//  i_clk           in   1      system clock; single clock domain
//  i_rst_n         in   1      reset, synchronous, active-low
//  i_flag_counter  in   1      count request from state machine; level, held for whole segment
//  i_count_ena     in   CNT_W  segment length in ticks; sampled only at load
//  o_enable        out  1      one-cycle pulse: segment complete
//  o_busy          out  1      high while in RUN
//  o_tick_count    out  CNT_W  ticks elapsed in current segment (debug/display)
// BEHAVIOUR
//  Interface: one clock i_clk; reset i_rst_n synchronous, active-low.
//  Reset (i_rst_n==0 at posedge)
//   - state=IDLE; prescaler=0; tick count=0; target=0.
//   - o_enable=0, o_busy=0, o_tick_count=0.
//   - Reset overrides every other input, including mid-RUN; no pulse is emitted.
//  FSM states: IDLE, RUN, DONE (registered state)
//  IDLE
//   - If i_flag_counter==1: target<=i_count_ena; prescaler<=0; tick count<=0.
//   - If the loaded value is 0, go to DONE; otherwise go to RUN.
//   - If i_flag_counter==0: stay in IDLE.
//  RUN
//   - Prescaler counts 0..CYCLES_PER_TICK-1 and wraps to 0; tick = (prescaler==CYCLES_PER_TICK-1).
//   - On tick, tick count increments.
//   - On tick with tick count==target-1, go to DONE.
//   - RUN therefore lasts exactly target*CYCLES_PER_TICK cycles.
//   - i_count_ena changes during RUN are ignored; the target stays latched.
//   - If i_flag_counter==0 in any RUN cycle (abort): go to IDLE; clear prescaler and tick count;
//     no pulse. Abort takes priority over a coincident final tick.
//  DONE
//   - o_enable=1 for exactly this one cycle; next state is always IDLE.
//   - The forced IDLE cycle lets the state machine present its next i_count_ena before reload.
//  Outputs
//   - o_enable is a combinational decode of state==DONE; o_busy is a decode of state==RUN.
//   - o_tick_count shows the registered tick count; it reads 0 in IDLE and in DONE.
//  Latency
//   - Segment with target N>0: the load edge (IDLE->RUN) is followed by N*CYCLES_PER_TICK RUN
//     cycles, then one DONE cycle, then one IDLE cycle, then reload.
//   - Target N==0: IDLE -> DONE on the next cycle.
//  Widths: prescaler is $clog2(CYCLES_PER_TICK) bits, unsigned, no saturation (it wraps).
//   Tick count is CNT_W bits; it cannot overflow because it never exceeds target-1.
// STRUCTURE
//  - Package blink_pkg: typedef enum logic [1:0] {T_IDLE,T_RUN,T_DONE} timer_state_t;
//    localparam CNT_W=3; localparam ON_TICKS=3'd6, OFF_TICKS=3'd4.
//  - Sub-module tick_prescaler: parameter CYCLES_PER_TICK; ports i_clk, i_rst_n,
//    i_clear (synchronous clear to 0), i_run (count enable), o_tick (one-cycle pulse).
//  - Top: FSM, target register, tick counter, output decode.
// TESTING  (CYCLES_PER_TICK=4)
//  - Reset: hold i_rst_n=0 for 3 cycles with i_flag_counter=1
//    -> o_enable=0, o_busy=0, o_tick_count=0 throughout.
//  - Flag=1, count=6 -> o_busy high 24 cycles; o_enable pulses once, in the cycle after
//    the 24th RUN cycle; o_tick_count steps 0..5.
//  - Flag=1, count=0 -> o_enable pulses in the cycle after load; o_busy never asserts.
//  - Abort: count=6, drop flag at RUN cycle 10 -> IDLE next cycle, counters 0, no o_enable.
//    Also drop flag exactly at the final-tick cycle -> no pulse.
//  - Reset mid-RUN (cycle 13 of 24) -> IDLE next edge, all outputs 0;
//    after release with flag=1, count=4 -> pulse after 16 RUN cycles.
//  - Closed loop with a state-machine model (start pulse; ON=6, OFF=4 ticks):
//    -> exactly 6 o_enable pulses, segment lengths 24,16,24,16,24,16 cycles, then flag low.

Source files
------------

// File: rtl/blink_pkg.sv
// ---------------------------------------------------------------------------
// blink_pkg
//  Shared types and constants for the blink controller slice.
//  - timer_state_t : state encoding of the segment timer FSM
//  - CNT_W         : width of the tick-count request/target
//  - ON_TICKS / OFF_TICKS : segment lengths used by the blink state machine
// ---------------------------------------------------------------------------
package blink_pkg;

    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] ON_TICKS  = 3'd6;
    localparam logic [CNT_W-1:0] OFF_TICKS = 3'd4;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/blink_timer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//  Free-running divider that produces one tick every CYCLES_PER_TICK enabled
//  clock cycles. The counter counts 0..CYCLES_PER_TICK-1 and wraps to 0.
// Ports
//  i_clk    in  1  system clock
//  i_rst_n  in  1  synchronous active-low reset (counter to 0)
//  i_clear  in  1  synchronous clear to 0; wins over i_run
//  i_run    in  1  count enable
//  o_tick   out 1  one-cycle pulse in the last cycle of each tick period
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CYCLES_PER_TICK = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int PW = $clog2(CYCLES_PER_TICK);
    localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_TICK - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic          at_end_s;

    // Next-count logic: clear beats counting; wrap at the last cycle of a period.
    always_comb begin
        cnt_d    = cnt_q;
        at_end_s = (cnt_q == LAST);
        if (i_clear) begin
            cnt_d = {PW{1'b0}};
        end else if (i_run) begin
            if (at_end_s) begin
                cnt_d = {PW{1'b0}};
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= {PW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A tick is only reported on a cycle where the count actually advances.
    assign o_tick = i_run & ~i_clear & at_end_s;

endmodule

// File: rtl/blink_timer.sv
// ---------------------------------------------------------------------------
// blink_timer
//  Segment timer pacing the blink state machine. On a count request it latches
//  the requested length (in ticks), counts prescaled ticks, and at the end of
//  the segment returns a one-cycle o_enable pulse that advances the state
//  machine. A zero-length request completes on the next cycle.
// Ports
//  i_clk           in  1      system clock
//  i_rst_n         in  1      synchronous active-low reset
//  i_flag_counter  in  1      count request, held high for the whole segment
//  i_count_ena     in  CNT_W  segment length in ticks, sampled only at load
//  o_enable        out 1      one-cycle pulse: segment complete
//  o_busy          out 1      high while counting
//  o_tick_count    out CNT_W  ticks elapsed in the current segment
// ---------------------------------------------------------------------------
module blink_timer
    import blink_pkg::*;
#(
    parameter int CYCLES_PER_TICK = 50_000_000,
    parameter int CNT_W           = blink_pkg::CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flag_counter,
    input  logic [CNT_W-1:0] i_count_ena,
    output logic             o_enable,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_tick_count
);

    timer_state_t     state_q;
    timer_state_t     state_d;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] target_d;
    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;

    logic             presc_clear_s;
    logic             presc_run_s;
    logic             tick_s;

    // The prescaler only runs inside a live segment; anywhere else (including
    // the abort cycle) it is held at 0 so every segment starts on a full tick.
    assign presc_run_s   = (state_q == T_RUN);
    assign presc_clear_s = (state_q != T_RUN) | ~i_flag_counter;

    tick_prescaler #(
        .CYCLES_PER_TICK(CYCLES_PER_TICK)
    ) u_tick_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (presc_clear_s),
        .i_run   (presc_run_s),
        .o_tick  (tick_s)
    );

    // Next-state, target and tick-count logic.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        tick_cnt_d = tick_cnt_q;
        case (state_q)
            T_IDLE: begin
                if (i_flag_counter) begin
                    target_d   = i_count_ena;
                    tick_cnt_d = {CNT_W{1'b0}};
                    if (i_count_ena == {CNT_W{1'b0}}) begin
                        state_d = T_DONE;
                    end else begin
                        state_d = T_RUN;
                    end
                end else begin
                    state_d = T_IDLE;
                end
            end
            T_RUN: begin
                // Abort is checked first so a dropped request never yields a pulse,
                // even when it coincides with the final tick.
                if (!i_flag_counter) begin
                    state_d    = T_IDLE;
                    tick_cnt_d = {CNT_W{1'b0}};
                end else if (tick_s) begin
                    // target_q is non-zero in RUN, so target_q-1 cannot underflow.
                    if (tick_cnt_q == (target_q - CNT_W'(1))) begin
                        state_d    = T_DONE;
                        tick_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            T_DONE: begin
                // Forced IDLE cycle lets the state machine present its next length.
                state_d    = T_IDLE;
                tick_cnt_d = {CNT_W{1'b0}};
            end
            default: begin
                state_d    = T_IDLE;
                tick_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, target and tick-count registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= T_IDLE;
            target_q   <= {CNT_W{1'b0}};
            tick_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign o_enable     = (state_q == T_DONE);
    assign o_busy       = (state_q == T_RUN);
    assign o_tick_count = tick_cnt_q;

endmodule
